// File: rtl/instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit
//   Fetch stage of the multicycle RISC-V core. A fetch_start pulse from the
//   control FSM reads one 32-bit word from instruction memory and latches it
//   into the instruction register (IR). The decoded fields and the immediate
//   are driven from the IR. A misaligned PC or a memory timeout loads a NOP
//   into the IR and records the cause in fetch_fault.
//
//   Handshake: mem_req is held high with mem_addr stable until a cycle in
//   which mem_gnt is high. That cycle transfers the request. Exactly one
//   mem_rvalid cycle is then expected to return the data. mem_rvalid is
//   ignored in any state other than WAIT and DRAIN.
//
// Ports
//   clk, reset_n             clock (rising edge), async active-low reset
//   fetch_start, flush       request a fetch at pc_in / abort in-flight fetch
//   pc_in                    address to fetch
//   mem_req, mem_addr        read request and word address to memory
//   mem_gnt                  memory accepted mem_req this cycle
//   mem_rvalid, mem_rdata    read data return
//   busy                     state != IDLE
//   instr_valid              one-cycle pulse: IR updated
//   fetch_fault              sticky cause: 00 none, 01 misaligned, 10 timeout
//   fetch_pc                 PC latched with the last accepted fetch_start
//   Instr, OPcode, func3, func7, rd, rs1, rs2, imm   IR and decoded fields
//   state_dbg                current FSM state (IDLE=0, REQ=1, WAIT=2, DRAIN=3)
// ----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [31:0] RESET_INSTR = 32'h0000_0013,
    parameter int unsigned TIMEOUT     = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        fetch_start,
    input  logic        flush,
    input  logic [31:0] pc_in,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        instr_valid,
    output logic [1:0]  fetch_fault,
    output logic [31:0] fetch_pc,
    output logic [31:0] Instr,
    output logic [6:0]  OPcode,
    output logic [2:0]  func3,
    output logic [6:0]  func7,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [31:0] imm,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t        state;
    logic [31:0]   ir;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            ir          <= RESET_INSTR;
            fetch_pc    <= 32'd0;
            mem_req     <= 1'b0;
            mem_addr    <= 32'd0;
            instr_valid <= 1'b0;
            fetch_fault <= 2'b00;
            cnt         <= '0;
        end else begin
            instr_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    // flush in the same cycle drops the request
                    if (fetch_start && !flush) begin
                        mem_addr <= pc_in;
                        fetch_pc <= pc_in;
                        if (pc_in[1:0] != 2'b00) begin
                            ir          <= RESET_INSTR;
                            fetch_fault <= 2'b01;
                            instr_valid <= 1'b1;
                        end else begin
                            mem_req <= 1'b1;
                            state   <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_gnt) begin
                        // A granted request returns data even if flushed now,
                        // so that data is drained instead of abandoned.
                        mem_req <= 1'b0;
                        cnt     <= '0;
                        state   <= flush ? S_DRAIN : S_WAIT;
                    end else if (flush) begin
                        mem_req <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (flush) begin
                        if (mem_rvalid || cnt == CNT_LAST) begin
                            state <= S_IDLE;
                        end else begin
                            cnt   <= cnt + 1'b1;
                            state <= S_DRAIN;
                        end
                    end else if (mem_rvalid) begin
                        ir          <= mem_rdata;
                        fetch_fault <= 2'b00;
                        instr_valid <= 1'b1;
                        state       <= S_IDLE;
                    end else if (cnt == CNT_LAST) begin
                        ir          <= RESET_INSTR;
                        fetch_fault <= 2'b10;
                        instr_valid <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DRAIN: begin
                    // Discard the returning word, or give up after the same
                    // timeout budget without raising a fault.
                    if (mem_rvalid || cnt == CNT_LAST) begin
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy      = (state != S_IDLE);
    assign state_dbg = state;
    assign Instr     = ir;
    assign OPcode    = ir[6:0];
    assign func3     = ir[14:12];
    assign func7     = ir[31:25];
    assign rd        = ir[11:7];
    assign rs1       = ir[19:15];
    assign rs2       = ir[24:20];

    always_comb begin
        imm = 32'd0;
        case (ir[6:0])
            7'b0010011, 7'b0000011, 7'b1100111:
                imm = {{20{ir[31]}}, ir[31:20]};
            7'b0100011:
                imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            7'b1100011:
                imm = {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
            7'b0110111:
                imm = {ir[31:12], 12'b0};
            7'b1101111:
                imm = {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
            default:
                imm = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam int          TIMEOUT = 16;

    localparam int M_NORMAL     = 0;
    localparam int M_FLUSH_REQ  = 1;
    localparam int M_FLUSH_WAIT = 2;
    localparam int M_FLUSH_RV   = 3;
    localparam int M_TIMEOUT    = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        fetch_start, flush;
    logic [31:0] pc_in;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;
    logic        busy, instr_valid;
    logic [1:0]  fetch_fault;
    logic [31:0] fetch_pc, Instr, imm;
    logic [6:0]  OPcode, func7;
    logic [2:0]  func3;
    logic [4:0]  rd, rs1, rs2;
    logic [1:0]  state_dbg;

    int n_checks = 0;
    int n_err    = 0;

    // scoreboard: words expected to appear with each instr_valid pulse
    logic [31:0] exp_q[$];

    // reference model of the architecturally visible registers
    logic [31:0] m_ir, m_fpc;
    logic [1:0]  m_fault;

    instr_fetch_unit #(.RESET_INSTR(NOP), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n), .fetch_start(fetch_start), .flush(flush),
        .pc_in(pc_in), .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .busy(busy),
        .instr_valid(instr_valid), .fetch_fault(fetch_fault), .fetch_pc(fetch_pc),
        .Instr(Instr), .OPcode(OPcode), .func3(func3), .func7(func7), .rd(rd),
        .rs1(rs1), .rs2(rs2), .imm(imm), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Immediate computed with signed arithmetic from the ISA field layout.
    function automatic logic [31:0] ref_imm(input logic [31:0] ir);
        int s;
        s = $signed(ir);
        case (ir[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: return 32'(s >>> 20);
            7'b0100011: return 32'((s >>> 25) * 32) | 32'(ir[11:7]);
            7'b1100011: return 32'((s >>> 31) * 4096) | (32'(ir[7]) * 2048)
                             | (32'(ir[30:25]) * 32) | (32'(ir[11:8]) * 2);
            7'b0110111: return ir & 32'hFFFF_F000;
            7'b1101111: return 32'((s >>> 31) * 1048576) | (32'(ir[19:12]) * 4096)
                             | (32'(ir[20]) * 2048) | (32'(ir[30:21]) * 2);
            default:    return 32'd0;
        endcase
    endfunction

    // scoreboard monitor: every pulse must be expected and carry the right word
    always @(negedge clk) begin
        if (reset_n && instr_valid) begin
            if (exp_q.size() == 0) check_eq("unexpected_valid", 32'(instr_valid), 32'd0);
            else check_eq("valid_instr", Instr, exp_q.pop_front());
        end
    end

    task automatic check_fields(input string tag);
        check_eq({tag, "_instr"}, Instr, m_ir);
        check_eq({tag, "_fault"}, 32'(fetch_fault), 32'(m_fault));
        check_eq({tag, "_fpc"}, fetch_pc, m_fpc);
        check_eq({tag, "_opcode"}, 32'(OPcode), 32'(m_ir & 32'h7F));
        check_eq({tag, "_func3"}, 32'(func3), (m_ir >> 12) & 32'h7);
        check_eq({tag, "_func7"}, 32'(func7), m_ir >> 25);
        check_eq({tag, "_rd"}, 32'(rd), (m_ir >> 7) & 32'h1F);
        check_eq({tag, "_rs1"}, 32'(rs1), (m_ir >> 15) & 32'h1F);
        check_eq({tag, "_rs2"}, 32'(rs2), (m_ir >> 20) & 32'h1F);
        check_eq({tag, "_imm"}, imm, ref_imm(m_ir));
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // driver: one complete fetch transaction, all edges taken at negedge
    task automatic run_fetch(input logic [31:0] pc, input int gnt_dly, input int rv_dly,
                             input int mode, input logic [31:0] data);
        @(negedge clk);
        if (pc[1:0] != 2'b00) begin
            exp_q.push_back(NOP);
            m_ir    = NOP;
            m_fault = 2'b01;
        end
        m_fpc       = pc;
        fetch_start = 1'b1;
        pc_in       = pc;
        @(negedge clk);
        fetch_start = 1'b0;
        pc_in       = $urandom;
        if (pc[1:0] != 2'b00) begin
            check_eq("misal_no_req", 32'(mem_req), 32'd0);
            check_eq("misal_valid", 32'(instr_valid), 32'd1);
            @(negedge clk);
            check_eq("misal_pulse_once", 32'(instr_valid), 32'd0);
        end else begin
            check_eq("req_mem_req", 32'(mem_req), 32'd1);
            check_eq("req_addr", mem_addr, pc);
            check_eq("req_busy", 32'(busy), 32'd1);
            // stray fetch_start and rvalid while waiting for the grant are ignored
            for (int i = 0; i < gnt_dly; i++) begin
                fetch_start = 1'($urandom_range(0, 1));
                pc_in       = pc + 32'd4;
                mem_rvalid  = 1'($urandom_range(0, 1));
                mem_rdata   = $urandom;
                @(negedge clk);
                fetch_start = 1'b0;
                mem_rvalid  = 1'b0;
                check_eq("req_hold_addr", mem_addr, pc);
                check_eq("req_hold_req", 32'(mem_req), 32'd1);
            end
            if (mode == M_FLUSH_REQ) begin
                flush = 1'b1;
                @(negedge clk);
                flush = 1'b0;
                check_eq("flush_req_drop", 32'(mem_req), 32'd0);
                check_eq("flush_req_valid", 32'(instr_valid), 32'd0);
            end else begin
                mem_gnt = 1'b1;
                @(negedge clk);
                mem_gnt = 1'b0;
                check_eq("wait_no_req", 32'(mem_req), 32'd0);
                check_eq("wait_busy", 32'(busy), 32'd1);
                case (mode)
                    M_NORMAL: begin
                        repeat (rv_dly) @(negedge clk);
                        exp_q.push_back(data);
                        m_ir       = data;
                        m_fault    = 2'b00;
                        mem_rvalid = 1'b1;
                        mem_rdata  = data;
                        @(negedge clk);
                        mem_rvalid = 1'b0;
                        check_eq("cap_valid", 32'(instr_valid), 32'd1);
                    end
                    M_FLUSH_WAIT: begin
                        flush = 1'b1;
                        @(negedge clk);
                        flush = 1'b0;
                        repeat (rv_dly) @(negedge clk);
                        check_eq("drain_busy", 32'(busy), 32'd1);
                        mem_rvalid = 1'b1;
                        mem_rdata  = data;
                        @(negedge clk);
                        mem_rvalid = 1'b0;
                        check_eq("drain_done", 32'(busy), 32'd0);
                        check_eq("drain_no_valid", 32'(instr_valid), 32'd0);
                    end
                    M_FLUSH_RV: begin
                        repeat (rv_dly) @(negedge clk);
                        flush      = 1'b1;
                        mem_rvalid = 1'b1;
                        mem_rdata  = data;
                        @(negedge clk);
                        flush      = 1'b0;
                        mem_rvalid = 1'b0;
                        check_eq("flush_rv_idle", 32'(busy), 32'd0);
                        check_eq("flush_rv_no_valid", 32'(instr_valid), 32'd0);
                    end
                    default: begin
                        exp_q.push_back(NOP);
                        m_ir    = NOP;
                        m_fault = 2'b10;
                        repeat (TIMEOUT - 1) @(negedge clk);
                        check_eq("to_still_busy", 32'(busy), 32'd1);
                        @(negedge clk);
                        check_eq("to_valid", 32'(instr_valid), 32'd1);
                        check_eq("to_idle", 32'(busy), 32'd0);
                        mem_rvalid = 1'b1;
                        mem_rdata  = data;
                        @(negedge clk);
                        mem_rvalid = 1'b0;
                        check_eq("late_rv_ignored", 32'(instr_valid), 32'd0);
                    end
                endcase
            end
        end
        @(negedge clk);
        check_fields("txn");
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops[8] = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
                               7'b1100011, 7'b0110111, 7'b1101111, 7'b0110011};
        logic [31:0] w;
        w = $urandom;
        w[6:0] = ops[$urandom_range(0, 7)];
        return w;
    endfunction

    initial begin
        reset_n     = 1'b0;
        fetch_start = 1'b0;
        flush       = 1'b0;
        pc_in       = 32'd0;
        mem_gnt     = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = 32'd0;
        m_ir        = NOP;
        m_fpc       = 32'd0;
        m_fault     = 2'b00;
        repeat (3) @(negedge clk);
        check_eq("rst_state", 32'(state_dbg), 32'd0);
        check_eq("rst_mem_req", 32'(mem_req), 32'd0);
        check_eq("rst_mem_addr", mem_addr, 32'd0);
        check_eq("rst_valid", 32'(instr_valid), 32'd0);
        check_fields("rst");
        reset_n = 1'b1;

        // zero-wait fetch: addi x1,x0,5
        run_fetch(32'h10, 0, 0, M_NORMAL, 32'h0050_0093);
        check_eq("t1_imm", imm, 32'd5);
        check_eq("t1_rd", 32'(rd), 32'd1);
        check_eq("t1_fpc", fetch_pc, 32'h10);

        run_fetch(32'h12, 0, 0, M_NORMAL, 32'hDEAD_BEEF);
        check_eq("t2_instr", Instr, NOP);
        check_eq("t2_fault", 32'(fetch_fault), 32'd1);

        run_fetch(32'h20, 0, 0, M_TIMEOUT, 32'h1234_5678);
        check_eq("t3_fault", 32'(fetch_fault), 32'd2);

        run_fetch(32'h24, 0, 0, M_NORMAL, 32'h1234_50B7);
        check_eq("t5_lui_imm", imm, 32'h1234_5000);
        run_fetch(32'h28, 1, 2, M_FLUSH_WAIT, 32'hFE00_0EE3);
        check_eq("t4_ir_kept", Instr, 32'h1234_50B7);
        run_fetch(32'h2C, 0, TIMEOUT - 1, M_NORMAL, 32'hFE00_0EE3);

        // flush and fetch_start together in IDLE: request dropped
        @(negedge clk);
        fetch_start = 1'b1;
        flush       = 1'b1;
        pc_in       = 32'h100;
        @(negedge clk);
        fetch_start = 1'b0;
        flush       = 1'b0;
        check_eq("fs_flush_busy", 32'(busy), 32'd0);
        check_eq("fs_flush_req", 32'(mem_req), 32'd0);
        check_eq("fs_flush_valid", 32'(instr_valid), 32'd0);
        check_fields("fs_flush");

        // randomized transactions against the model
        for (int n = 0; n < 80; n++) begin
            logic [31:0] pc;
            int mode, rv;
            pc = $urandom & 32'h0000_FFFC;
            if ($urandom_range(0, 4) == 0) pc[1:0] = 2'($urandom_range(1, 3));
            mode = $urandom_range(0, 4);
            case (mode)
                M_NORMAL:     rv = $urandom_range(0, TIMEOUT - 1);
                M_FLUSH_WAIT: rv = $urandom_range(0, TIMEOUT - 3);
                default:      rv = $urandom_range(0, 4);
            endcase
            run_fetch(pc, $urandom_range(0, 3), rv, mode, rand_instr());
        end

        // async reset in the middle of WAIT
        run_fetch(32'h30, 0, 0, M_NORMAL, 32'h1234_50B7);
        @(negedge clk);
        fetch_start = 1'b1;
        pc_in       = 32'h40;
        @(negedge clk);
        fetch_start = 1'b0;
        mem_gnt     = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("pre_rst_busy", 32'(busy), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        m_ir    = NOP;
        m_fpc   = 32'd0;
        m_fault = 2'b00;
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_instr", Instr, NOP);
        check_eq("arst_mem_req", 32'(mem_req), 32'd0);
        check_eq("arst_fpc", fetch_pc, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_fields("post_rst");

        check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
